// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter slice.
// Contents: Wishbone bus field widths and the arbiter FSM state encoding.
package wb_rr_arbiter_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Rotating-priority requester picker (purely combinational).
// Ports:
//   req   in   NUM_M  request vector, one bit per master
//   last  in   IDX_W  index of the master granted most recently
//   valid out  1      at least one request is present
//   idx   out  IDX_W  first requester found scanning last+1, last+2, ... mod NUM_M
module rr_pick #(
  parameter int NUM_M = 3,
  parameter int IDX_W = 3
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the farthest candidate back to the nearest one so that the
  // nearest requester after 'last' is the final assignment and wins.
  always_comb begin
    int k;
    k     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_M; i >= 1; i--) begin
      k = (int'(last) + i) % NUM_M;
      if (req[k]) begin
        valid = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave port among NUM_M masters.
// A grant is held for a whole cyc envelope so bursts stay atomic, and a bus
// watchdog returns err to the granted master when the slave never acks.
//
// Handshake: a beat is offered while s_stb_o=1 (which implies s_cyc_o=1) and
// completes on the cycle s_ack_i=1; the ack is forwarded only to the granted
// master and only while its cyc is still high, so a late ack after the master
// abandoned the envelope is dropped.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   m_adr_i/m_dat_i/m_sel_i  packed master fields, master k at slice k
//   m_we_i/m_cyc_i/m_stb_i   master controls, one bit per master
//   m_dat_o                  slave read data broadcast to all masters
//   m_ack_o/m_err_o          ack / watchdog err, granted master only
//   s_*                      slave side of the granted master
//   grant_o                  one-hot current grant
//   dbg_state_o              FSM state (0 = IDLE, 1 = BUSY)
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_M   = 3,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WB_ADR_W*NUM_M-1:0] m_adr_i,
  input  logic [WB_DAT_W*NUM_M-1:0] m_dat_i,
  input  logic [WB_SEL_W*NUM_M-1:0] m_sel_i,
  input  logic [NUM_M-1:0]          m_we_i,
  input  logic [NUM_M-1:0]          m_cyc_i,
  input  logic [NUM_M-1:0]          m_stb_i,
  output logic [WB_DAT_W-1:0]       m_dat_o,
  output logic [NUM_M-1:0]          m_ack_o,
  output logic [NUM_M-1:0]          m_err_o,
  output logic [WB_ADR_W-1:0]       s_adr_o,
  output logic [WB_DAT_W-1:0]       s_dat_o,
  output logic [WB_SEL_W-1:0]       s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  input  logic [WB_DAT_W-1:0]       s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_M-1:0]          grant_o,
  output logic                      dbg_state_o
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] g, g_nxt;
  logic [IDX_W-1:0] last, last_nxt;
  logic [TO_W-1:0]  wdog, wdog_nxt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             busy;
  logic             ack_g;
  logic             to_hit;
  logic [NUM_M-1:0] g_oh;

  rr_pick #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (m_cyc_i),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy        = (state == ST_BUSY);
  assign g_oh        = busy ? (NUM_M'(1) << g) : '0;
  assign grant_o     = g_oh;
  assign dbg_state_o = state;

  // Slave-side mux; everything is forced to 0 outside an envelope.
  assign s_cyc_o = busy & m_cyc_i[g];
  assign s_stb_o = s_cyc_o & m_stb_i[g];
  assign s_we_o  = busy & m_we_i[g];
  assign s_adr_o = busy ? m_adr_i[int'(g)*WB_ADR_W +: WB_ADR_W] : '0;
  assign s_dat_o = busy ? m_dat_i[int'(g)*WB_DAT_W +: WB_DAT_W] : '0;
  assign s_sel_o = busy ? m_sel_i[int'(g)*WB_SEL_W +: WB_SEL_W] : '0;
  assign m_dat_o = s_dat_i;

  assign ack_g   = s_ack_i & s_cyc_o;
  assign m_ack_o = ack_g ? g_oh : '0;

  // Timeout fires on the TIMEOUT-th consecutive unacked strobe cycle; an ack
  // in that same cycle takes precedence.
  if (TIMEOUT > 0) begin : g_wdog
    assign to_hit = s_stb_o & ~s_ack_i & (wdog == TO_W'(TIMEOUT - 1));
  end else begin : g_no_wdog
    assign to_hit = 1'b0;
  end
  assign m_err_o = to_hit ? g_oh : '0;

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    last_nxt  = last;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nxt = ST_BUSY;
          g_nxt     = pick_idx;
        end
      end
      ST_BUSY: begin
        // Release always returns to IDLE for one cycle: no back-to-back grant.
        if (!m_cyc_i[g]) begin
          state_nxt = ST_IDLE;
          last_nxt  = g;
          g_nxt     = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wdog_nxt = wdog;
    if ((TIMEOUT == 0) || !busy || !m_cyc_i[g] || ack_g || to_hit) begin
      wdog_nxt = '0;
    end else if (s_stb_o) begin
      wdog_nxt = wdog + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      g     <= '0;
      last  <= IDX_W'(NUM_M - 1);
      wdog  <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      last  <= last_nxt;
      wdog  <= wdog_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int NUM_M = 3;

  logic                  clk;
  logic                  rst;
  logic [32*NUM_M-1:0]   m_adr_i;
  logic [32*NUM_M-1:0]   m_dat_i;
  logic [4*NUM_M-1:0]    m_sel_i;
  logic [NUM_M-1:0]      m_we_i;
  logic [NUM_M-1:0]      m_cyc_i;
  logic [NUM_M-1:0]      m_stb_i;
  logic [31:0]           m_dat_o;
  logic [NUM_M-1:0]      m_ack_o;
  logic [NUM_M-1:0]      m_err_o;
  logic [31:0]           s_adr_o;
  logic [31:0]           s_dat_o;
  logic [3:0]            s_sel_o;
  logic                  s_we_o;
  logic                  s_cyc_o;
  logic                  s_stb_o;
  logic [31:0]           s_dat_i;
  logic                  s_ack_i;
  logic [NUM_M-1:0]      grant_o;
  logic                  dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_rr_arbiter #(
    .NUM_M   (NUM_M),
    .IDX_W   (3),
    .TIMEOUT (8),
    .TO_W    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_adr_i     (m_adr_i),
    .m_dat_i     (m_dat_i),
    .m_sel_i     (m_sel_i),
    .m_we_i      (m_we_i),
    .m_cyc_i     (m_cyc_i),
    .m_stb_i     (m_stb_i),
    .m_dat_o     (m_dat_o),
    .m_ack_o     (m_ack_o),
    .m_err_o     (m_err_o),
    .s_adr_o     (s_adr_o),
    .s_dat_o     (s_dat_o),
    .s_sel_o     (s_sel_o),
    .s_we_o      (s_we_o),
    .s_cyc_o     (s_cyc_o),
    .s_stb_o     (s_stb_o),
    .s_dat_i     (s_dat_i),
    .s_ack_i     (s_ack_i),
    .grant_o     (grant_o),
    .dbg_state_o (dbg_state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] adr_of(input int k);
    return 32'h8000_0000 | (32'(k) << 8);
  endfunction

  function automatic logic [31:0] dat_of(input int k);
    return 32'h5A00_0000 | 32'(k);
  endfunction

  function automatic logic [3:0] sel_of(input int k);
    logic [3:0] s;
    s = 4'b0001 << k;
    return s;
  endfunction

  // Driver: settle after the falling edge, far from the rising edge.
  task automatic settle();
    #1;
  endtask

  initial begin
    int order[4];
    logic [2:0] exp_err;
    logic [2:0] exp_ack;
    order = '{0, 1, 2, 0};

    rst     = 1'b1;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = 3'b110;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    for (int k = 0; k < NUM_M; k++) begin
      m_adr_i[32*k +: 32] = adr_of(k);
      m_dat_i[32*k +: 32] = dat_of(k);
      m_sel_i[4*k +: 4]   = sel_of(k);
    end
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk); settle();
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_state", 32'(dbg_state_o), 32'h0);
    check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_s_stb", 32'(s_stb_o), 32'h0);
    check("rst_s_adr", s_adr_o, 32'h0);
    check("rst_ack", 32'(m_ack_o), 32'h0);
    check("rst_err", 32'(m_err_o), 32'h0);

    // Test 1: all three request continuously -> grants 0,1,2,0 with an idle gap
    @(negedge clk);
    rst     = 1'b1;
    m_cyc_i = 3'b111;
    settle();
    check("t1_arb_latency", 32'(grant_o), 32'h0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk); settle();
      check("t1_grant", 32'(grant_o), 32'(3'b001 << order[n]));
      check("t1_state_busy", 32'(dbg_state_o), 32'h1);
      check("t1_s_adr", s_adr_o, adr_of(order[n]));
      check("t1_s_dat", s_dat_o, dat_of(order[n]));
      m_cyc_i = 3'b111 & ~(3'b001 << order[n]);
      settle();
      check("t1_drop_s_cyc", 32'(s_cyc_o), 32'h0);
      @(negedge clk); settle();
      check("t1_idle_gap", 32'(grant_o), 32'h0);
      check("t1_state_idle", 32'(dbg_state_o), 32'h0);
      // Last round hands over to test 2: M0 and M1 request, M1 is next in turn.
      m_cyc_i = (n == 3) ? 3'b011 : 3'b111;
    end

    // Test 2: M1 4-beat burst while M0 requests and strobes
    @(negedge clk); settle();
    check("t2_grant_m1", 32'(grant_o), 32'h2);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      m_stb_i = 3'b011;
      s_ack_i = 1'b1;
      s_dat_i = 32'hCAFE_0000 + 32'(b);
      settle();
      check("t2_ack_m1_only", 32'(m_ack_o), 32'h2);
      check("t2_err", 32'(m_err_o), 32'h0);
      check("t2_s_we", 32'(s_we_o), 32'h1);
      check("t2_s_sel", 32'(s_sel_o), 32'h2);
      check("t2_m_dat", m_dat_o, 32'hCAFE_0000 + 32'(b));
      check("t2_grant_held", 32'(grant_o), 32'h2);
    end
    @(negedge clk);
    m_stb_i = 3'b000;
    s_ack_i = 1'b0;
    m_cyc_i = 3'b001;
    settle();
    check("t2_release_s_cyc", 32'(s_cyc_o), 32'h0);
    check("t2_release_ack", 32'(m_ack_o), 32'h0);
    @(negedge clk); settle();
    check("t2_idle_gap", 32'(grant_o), 32'h0);
    @(negedge clk); settle();
    check("t2_grant_m0", 32'(grant_o), 32'h1);
    check("t2_s_we_m0", 32'(s_we_o), 32'h0);

    // Tests 3/4: slave never acks (err on 8th stb cycle), then an ack lands
    // exactly on the timeout cycle (ack wins, counter restarts from 0).
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      m_stb_i = 3'b001;
      s_ack_i = (i == 16);
      settle();
      exp_err = (i == 8 || i == 24) ? 3'b001 : 3'b000;
      exp_ack = (i == 16) ? 3'b001 : 3'b000;
      check("t3_err", 32'(m_err_o), 32'(exp_err));
      check("t3_ack", 32'(m_ack_o), 32'(exp_ack));
      if (i == 9) check("t3_grant_kept", 32'(grant_o), 32'h1);
    end

    // Test 5: master abandons cyc while stb pending; slave acks late
    @(negedge clk);
    s_ack_i = 1'b0;
    m_cyc_i = 3'b000;
    settle();
    check("t5_s_cyc_drop", 32'(s_cyc_o), 32'h0);
    check("t5_s_stb_drop", 32'(s_stb_o), 32'h0);
    s_ack_i = 1'b1;
    settle();
    check("t5_ack_same_cycle", 32'(m_ack_o), 32'h0);
    @(negedge clk);
    settle();
    check("t5_late_ack", 32'(m_ack_o), 32'h0);
    check("t5_err", 32'(m_err_o), 32'h0);
    check("t5_state_idle", 32'(dbg_state_o), 32'h0);
    s_ack_i = 1'b0;
    m_stb_i = 3'b000;

    // Test 6: asynchronous reset in the middle of an M2 burst
    m_cyc_i = 3'b100;
    @(negedge clk);
    @(negedge clk); settle();
    check("t6_grant_m2", 32'(grant_o), 32'h4);
    m_stb_i = 3'b100;
    s_ack_i = 1'b1;
    settle();
    check("t6_ack_m2", 32'(m_ack_o), 32'h4);
    check("t6_s_we", 32'(s_we_o), 32'h1);
    rst = 1'b0;
    settle();
    check("t6_rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("t6_rst_s_stb", 32'(s_stb_o), 32'h0);
    check("t6_rst_s_adr", s_adr_o, 32'h0);
    check("t6_rst_s_we", 32'(s_we_o), 32'h0);
    check("t6_rst_ack", 32'(m_ack_o), 32'h0);
    check("t6_rst_err", 32'(m_err_o), 32'h0);
    check("t6_rst_grant", 32'(grant_o), 32'h0);
    @(negedge clk);
    rst     = 1'b1;
    m_cyc_i = 3'b111;
    m_stb_i = 3'b000;
    s_ack_i = 1'b0;
    @(negedge clk); settle();
    check("t6_first_grant_m0", 32'(grant_o), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
